// File: rtl/alu_muldiv_control.sv
// Execute-stage ALU control decoder with an iterative RV32M/RV64M multiply/divide unit.
// aluControl classes: 0 load/store, 1 branch, 2 R-type, 3 I-type, 4 JAL, 5 JALR, 6 LUI, 7 AUIPC.
module alu_muldiv_control #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            in_valid,
  input  logic            flush,
  input  logic [2:0]      aluControl,
  input  logic [2:0]      func3,
  input  logic [6:0]      func7,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic [4:0]      aluControlOut,
  output logic            illegal_op,
  output logic            stall,
  output logic            md_valid,
  output logic [XLEN-1:0] md_result
);

  localparam logic [2:0] CLS_B = 3'd1;
  localparam logic [2:0] CLS_R = 3'd2;
  localparam logic [2:0] CLS_I = 3'd3;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MD   = 7'b0000001;

  localparam logic [XLEN-1:0]  INT_MIN = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(XLEN - 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  function automatic logic [4:0] base_op(input logic [2:0] f3);
    case (f3)
      3'b000:  base_op = 5'b00000;
      3'b001:  base_op = 5'b00101;
      3'b010:  base_op = 5'b01000;
      3'b011:  base_op = 5'b01001;
      3'b100:  base_op = 5'b00100;
      3'b101:  base_op = 5'b00110;
      3'b110:  base_op = 5'b00011;
      default: base_op = 5'b00010;
    endcase
  endfunction

  function automatic logic [4:0] branch_op(input logic [2:0] f3);
    case (f3)
      3'b000:  branch_op = 5'b01010;
      3'b001:  branch_op = 5'b01011;
      3'b100:  branch_op = 5'b01100;
      3'b101:  branch_op = 5'b01101;
      3'b110:  branch_op = 5'b01110;
      default: branch_op = 5'b01111;
    endcase
  endfunction

  logic is_md;

  always_comb begin
    aluControlOut = 5'b00000;
    illegal_op    = 1'b0;
    is_md         = 1'b0;
    case (aluControl)
      CLS_B: begin
        if (func3 == 3'b010 || func3 == 3'b011) illegal_op = 1'b1;
        else                                    aluControlOut = branch_op(func3);
      end
      CLS_R: begin
        if (func7 == F7_BASE) begin
          aluControlOut = base_op(func3);
        end else if (func7 == F7_ALT && func3 == 3'b000) begin
          aluControlOut = 5'b00001;
        end else if (func7 == F7_ALT && func3 == 3'b101) begin
          aluControlOut = 5'b00111;
        end else if (func7 == F7_MD) begin
          aluControlOut = {2'b10, func3};
          is_md         = 1'b1;
        end else begin
          illegal_op = 1'b1;
        end
      end
      CLS_I: begin
        if (func3 == 3'b101) begin
          if (func7 == F7_BASE)     aluControlOut = 5'b00110;
          else if (func7 == F7_ALT) aluControlOut = 5'b00111;
          else                      illegal_op = 1'b1;
        end else begin
          aluControlOut = base_op(func3);
        end
      end
      default: aluControlOut = 5'b00000;
    endcase
  end

  // Operand preparation: magnitudes, result sign and divide special cases.
  logic            a_signed, b_signed, a_neg, b_neg, res_neg;
  logic            div_zero, div_ovf;
  logic [XLEN-1:0] mag_a, mag_b, special_res;

  always_comb begin
    a_signed = ~(func3 == 3'b011 || func3 == 3'b101 || func3 == 3'b111);
    b_signed = (func3 == 3'b000 || func3 == 3'b001 || func3 == 3'b100 || func3 == 3'b110);
    a_neg    = a_signed & op_a[XLEN-1];
    b_neg    = b_signed & op_b[XLEN-1];
    mag_a    = a_neg ? -op_a : op_a;
    mag_b    = b_neg ? -op_b : op_b;
    case (func3)
      3'b000, 3'b001, 3'b100: res_neg = a_neg ^ b_neg;
      3'b010, 3'b110:         res_neg = a_neg;
      default:                res_neg = 1'b0;
    endcase
    div_zero = func3[2] & (op_b == '0);
    div_ovf  = func3[2] & ~func3[0] & (op_a == INT_MIN) & (op_b == '1);
    if (div_zero) special_res = func3[1] ? op_a : '1;
    else          special_res = func3[1] ? '0 : op_a;
  end

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [XLEN-1:0]     res_q, res_d;
  logic [2:0]          op_q, op_d;
  logic                neg_q, neg_d;
  logic [XLEN-1:0]     opnd_q, opnd_d;
  logic [XLEN:0]       acc_q, acc_d;
  logic [XLEN-1:0]     lo_q, lo_d;

  logic capture;
  assign capture = (state_q == S_IDLE) & in_valid & is_md & ~flush;

  // One shift-add or restoring-divide step on {acc, lo}.
  logic [XLEN:0]     mul_sum, mul_acc, div_shift, div_acc, step_acc;
  logic [XLEN+1:0]   div_diff;
  logic [XLEN-1:0]   mul_lo, div_lo, step_lo;
  logic              div_ok;

  always_comb begin
    mul_sum   = acc_q + (lo_q[0] ? {1'b0, opnd_q} : '0);
    mul_acc   = {1'b0, mul_sum[XLEN:1]};
    mul_lo    = {mul_sum[0], lo_q[XLEN-1:1]};
    div_shift = {acc_q[XLEN-1:0], lo_q[XLEN-1]};
    div_diff  = {1'b0, div_shift} - {2'b00, opnd_q};
    div_ok    = ~div_diff[XLEN+1];
    div_acc   = div_ok ? div_diff[XLEN:0] : div_shift;
    div_lo    = {lo_q[XLEN-2:0], div_ok};
    step_acc  = op_q[2] ? div_acc : mul_acc;
    step_lo   = op_q[2] ? div_lo  : mul_lo;
  end

  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0]   quo_s, rem_s, final_res;

  always_comb begin
    prod   = {step_acc[XLEN-1:0], step_lo};
    prod_s = neg_q ? -prod : prod;
    quo_s  = neg_q ? -step_lo : step_lo;
    rem_s  = neg_q ? -step_acc[XLEN-1:0] : step_acc[XLEN-1:0];
    case (op_q)
      3'b000:                 final_res = prod_s[XLEN-1:0];
      3'b001, 3'b010, 3'b011: final_res = prod_s[2*XLEN-1:XLEN];
      3'b100, 3'b101:         final_res = quo_s;
      default:                final_res = rem_s;
    endcase
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    res_d   = res_q;
    op_d    = op_q;
    neg_d   = neg_q;
    opnd_d  = opnd_q;
    acc_d   = acc_q;
    lo_d    = lo_q;
    case (state_q)
      S_IDLE: begin
        if (capture) begin
          op_d    = func3;
          neg_d   = res_neg;
          opnd_d  = func3[2] ? mag_b : mag_a;
          lo_d    = func3[2] ? mag_a : mag_b;
          acc_d   = '0;
          count_d = '0;
          if (div_zero || div_ovf) begin
            res_d   = special_res;
            state_d = S_DONE;
          end else begin
            state_d = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        acc_d = step_acc;
        lo_d  = step_lo;
        if (count_q == LAST) begin
          res_d   = final_res;
          state_d = S_DONE;
        end else begin
          count_d = count_q + CNT_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (flush) state_d = S_IDLE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      count_q <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      res_q   <= res_d;
    end
  end

  // Datapath registers are fully rewritten on capture, so they carry no reset.
  always_ff @(posedge clk) begin
    op_q   <= op_d;
    neg_q  <= neg_d;
    opnd_q <= opnd_d;
    acc_q  <= acc_d;
    lo_q   <= lo_d;
  end

  assign stall     = reset_n & (capture | (state_q == S_BUSY));
  assign md_valid  = (state_q == S_DONE);
  assign md_result = res_q;

endmodule

// File: tb/tb_alu_muldiv_control.sv
// Self-checking bench for alu_muldiv_control (XLEN = 32) with a behavioural M-extension model.
`timescale 1ns/1ps
module tb_alu_muldiv_control;

  localparam logic [2:0] C_LS = 3'd0, C_B = 3'd1, C_R = 3'd2, C_I = 3'd3;
  localparam logic [31:0] MIN32 = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        flush;
  logic [2:0]  alu_ctl;
  logic [2:0]  func3;
  logic [6:0]  func7;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [4:0]  alu_out;
  logic        illegal_op;
  logic        stall;
  logic        md_valid;
  logic [31:0] md_result;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_muldiv_control #(.XLEN(32)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .flush(flush),
    .aluControl(alu_ctl), .func3(func3), .func7(func7),
    .op_a(op_a), .op_b(op_b),
    .aluControlOut(alu_out), .illegal_op(illegal_op),
    .stall(stall), .md_valid(md_valid), .md_result(md_result)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Reference M-extension result computed with 64-bit integer arithmetic.
  function automatic logic [31:0] ref_md(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub, q;
    logic [63:0] p;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (f3)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == MIN32 && b == 32'hFFFF_FFFF) return a;
        q = sa / sb; return q[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        q = ua / ub; return q[31:0];
      end
      3'd6: begin
        if (b == 0) return a;
        if (a == MIN32 && b == 32'hFFFF_FFFF) return 32'd0;
        q = sa % sb; return q[31:0];
      end
      default: begin
        if (b == 0) return a;
        q = ua % ub; return q[31:0];
      end
    endcase
  endfunction

  function automatic bit ref_special(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    return f3[2] && (b == 0 || (!f3[0] && a == MIN32 && b == 32'hFFFF_FFFF));
  endfunction

  // Reference decode: returns {illegal, code}.
  function automatic logic [5:0] ref_dec(input logic [2:0] cls, input logic [2:0] f3, input logic [6:0] f7);
    logic [4:0] tbl [8];
    logic [4:0] k;
    tbl = '{5'd0, 5'd5, 5'd8, 5'd9, 5'd4, 5'd6, 5'd3, 5'd2};
    case (cls)
      C_B: begin
        if (f3 == 3'd2 || f3 == 3'd3) return {1'b1, 5'd0};
        k = {2'b00, f3};
        if (k >= 5'd4) k = k - 5'd2;
        return {1'b0, 5'd10 + k};
      end
      C_R: begin
        if (f7 == 7'h00) return {1'b0, tbl[f3]};
        if (f7 == 7'h20 && f3 == 3'd0) return {1'b0, 5'd1};
        if (f7 == 7'h20 && f3 == 3'd5) return {1'b0, 5'd7};
        if (f7 == 7'h01) return {1'b0, 2'b10, f3};
        return {1'b1, 5'd0};
      end
      C_I: begin
        if (f3 == 3'd5) begin
          if (f7 == 7'h00) return {1'b0, 5'd6};
          if (f7 == 7'h20) return {1'b0, 5'd7};
          return {1'b1, 5'd0};
        end
        return {1'b0, tbl[f3]};
      end
      default: return {1'b0, 5'd0};
    endcase
  endfunction

  task idle_inputs();
    in_valid = 1'b0; flush = 1'b0; alu_ctl = C_LS; func3 = 3'd0; func7 = 7'd0;
    op_a = 32'd0; op_b = 32'd0;
  endtask

  // Presents one M op until its result appears, then retires it and watches a few idle cycles.
  task automatic run_m(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output int sc, output int vc, output int vcyc);
    res = '0; sc = 0; vc = 0; vcyc = -1;
    @(negedge clk);
    in_valid = 1'b1; flush = 1'b0; alu_ctl = C_R; func3 = f3; func7 = 7'h01; op_a = a; op_b = b;
    for (int c = 0; c < 100 && vc == 0; c++) begin
      #1;
      if (stall) sc++;
      if (md_valid) begin vc++; vcyc = c; res = md_result; end
      @(negedge clk);
    end
    idle_inputs();
    for (int c = 0; c < 4; c++) begin
      #1;
      if (stall) sc++;
      if (md_valid) vc++;
      @(negedge clk);
    end
  endtask

  task test_reset();
    reset_n = 1'b0;
    idle_inputs();
    #3;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", stall); end
    checks++; if (md_valid !== 1'b0) begin errors++; $display("FAIL reset_md_valid got %b want 0", md_valid); end
    checks++; if (md_result !== 32'd0) begin errors++; $display("FAIL reset_md_result got %h want 0", md_result); end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_decode();
    logic [5:0] e;
    logic [2:0] cls, f3;
    logic [6:0] f7;
    int pick;
    bit is_m;
    @(negedge clk);
    in_valid = 1'b1; alu_ctl = C_R; func3 = 3'b101; func7 = 7'b0100000;
    #1;
    checks++; if (alu_out !== 5'b00111) begin errors++; $display("FAIL dec_sra got %b want 00111", alu_out); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL dec_sra_stall got %b want 0", stall); end
    @(negedge clk);
    alu_ctl = C_B; func3 = 3'b010; func7 = 7'd0;
    #1;
    checks++; if (alu_out !== 5'b00000 || illegal_op !== 1'b1)
      begin errors++; $display("FAIL dec_b010 got %b/%b want 00000/1", alu_out, illegal_op); end
    @(negedge clk);
    alu_ctl = C_R; func3 = 3'b110; func7 = 7'b0000001; op_a = 32'd9; op_b = 32'd4;
    #1;
    checks++; if (alu_out !== 5'b10110) begin errors++; $display("FAIL dec_rem got %b want 10110", alu_out); end
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL dec_rem_stall got %b want 1", stall); end
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b1;
    @(negedge clk);
    idle_inputs();
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      cls = 3'($urandom_range(0, 7));
      f3 = 3'($urandom_range(0, 7));
      pick = $urandom_range(0, 3);
      f7 = (pick == 0) ? 7'h00 : (pick == 1) ? 7'h20 : (pick == 2) ? 7'h01 : 7'($urandom);
      e = ref_dec(cls, f3, f7);
      is_m = (cls == C_R && f7 == 7'h01);
      alu_ctl = cls; func3 = f3; func7 = f7; in_valid = !is_m;
      op_a = $urandom; op_b = $urandom;
      #1;
      checks++; if (alu_out !== e[4:0])
        begin errors++; $display("FAIL dec_rand cls=%0d f3=%0d f7=%h got %b want %b", cls, f3, f7, alu_out, e[4:0]); end
      checks++; if (illegal_op !== e[5])
        begin errors++; $display("FAIL dec_rand_illegal cls=%0d f3=%0d f7=%h got %b want %b", cls, f3, f7, illegal_op, e[5]); end
      checks++; if (stall !== 1'b0 || md_valid !== 1'b0)
        begin errors++; $display("FAIL dec_rand_stall got %b/%b want 0/0", stall, md_valid); end
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_mul();
    logic [31:0] r; int sc, vc, vcyc;
    run_m(3'd0, 32'd7, 32'hFFFF_FFFD, r, sc, vc, vcyc);
    checks++; if (r !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mul_result got %h want ffffffeb", r); end
    checks++; if (sc != 33) begin errors++; $display("FAIL mul_stall_cycles got %0d want 33", sc); end
    checks++; if (vc != 1) begin errors++; $display("FAIL mul_valid_cycles got %0d want 1", vc); end
    checks++; if (vcyc != 33) begin errors++; $display("FAIL mul_latency got %0d want 33", vcyc); end
  endtask

  task automatic test_high_mul();
    logic [31:0] r; int sc, vc, vcyc;
    run_m(3'd1, 32'h8000_0000, 32'h8000_0000, r, sc, vc, vcyc);
    checks++; if (r !== 32'h4000_0000) begin errors++; $display("FAIL mulh got %h want 40000000", r); end
    run_m(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r, sc, vc, vcyc);
    checks++; if (r !== 32'hFFFF_FFFE) begin errors++; $display("FAIL mulhu got %h want fffffffe", r); end
    run_m(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r, sc, vc, vcyc);
    checks++; if (r !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mulhsu got %h want ffffffff", r); end
    checks++; if (vc != 1) begin errors++; $display("FAIL mulhsu_valid_cycles got %0d want 1", vc); end
  endtask

  task automatic test_div();
    logic [31:0] r; int sc, vc, vcyc;
    run_m(3'd4, 32'hFFFF_FFF9, 32'd2, r, sc, vc, vcyc);
    checks++; if (r !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_neg got %h want fffffffd", r); end
    checks++; if (sc != 33) begin errors++; $display("FAIL div_stall_cycles got %0d want 33", sc); end
    run_m(3'd6, 32'hFFFF_FFF9, 32'd2, r, sc, vc, vcyc);
    checks++; if (r !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rem_neg got %h want ffffffff", r); end
    run_m(3'd5, 32'd100, 32'd7, r, sc, vc, vcyc);
    checks++; if (r !== 32'd14) begin errors++; $display("FAIL divu got %h want 0000000e", r); end
    run_m(3'd7, 32'd100, 32'd7, r, sc, vc, vcyc);
    checks++; if (r !== 32'd2) begin errors++; $display("FAIL remu got %h want 00000002", r); end
  endtask

  task automatic test_div_special();
    logic [31:0] r; int sc, vc, vcyc;
    run_m(3'd5, 32'd5, 32'd0, r, sc, vc, vcyc);
    checks++; if (r !== 32'hFFFF_FFFF) begin errors++; $display("FAIL divu_zero got %h want ffffffff", r); end
    checks++; if (sc != 1) begin errors++; $display("FAIL divu_zero_stall got %0d want 1", sc); end
    checks++; if (vcyc != 1 || vc != 1) begin errors++; $display("FAIL divu_zero_valid got cyc %0d cnt %0d want cyc 1 cnt 1", vcyc, vc); end
    run_m(3'd7, 32'd5, 32'd0, r, sc, vc, vcyc);
    checks++; if (r !== 32'd5) begin errors++; $display("FAIL remu_zero got %h want 00000005", r); end
    run_m(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, r, sc, vc, vcyc);
    checks++; if (r !== 32'h8000_0000) begin errors++; $display("FAIL div_ovf got %h want 80000000", r); end
    checks++; if (sc != 1) begin errors++; $display("FAIL div_ovf_stall got %0d want 1", sc); end
    run_m(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, r, sc, vc, vcyc);
    checks++; if (r !== 32'd0) begin errors++; $display("FAIL rem_ovf got %h want 00000000", r); end
  endtask

  task automatic test_flush();
    int vseen, sseen;
    @(negedge clk);
    in_valid = 1'b1; alu_ctl = C_R; func3 = 3'd0; func7 = 7'h01; op_a = 32'd3; op_b = 32'd5; flush = 1'b1;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL flush_priority_stall got %b want 0", stall); end
    @(negedge clk);
    idle_inputs();
    #1;
    checks++; if (stall !== 1'b0 || md_valid !== 1'b0)
      begin errors++; $display("FAIL flush_no_capture got %b/%b want 0/0", stall, md_valid); end
    @(negedge clk);
    in_valid = 1'b1; alu_ctl = C_R; func3 = 3'd5; func7 = 7'h01; op_a = 32'd1000; op_b = 32'd3;
    repeat (11) @(negedge clk);
    flush = 1'b1; in_valid = 1'b0;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL flush_busy_stall got %b want 1", stall); end
    @(negedge clk);
    idle_inputs();
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL flush_idle_stall got %b want 0", stall); end
    vseen = 0; sseen = 0;
    for (int c = 0; c < 40; c++) begin
      if (md_valid) vseen++;
      if (stall) sseen++;
      @(negedge clk); #1;
    end
    checks++; if (vseen != 0 || sseen != 0)
      begin errors++; $display("FAIL flush_no_valid got valid %0d stall %0d want 0 0", vseen, sseen); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] r; int sc, vc, vcyc;
    @(negedge clk);
    in_valid = 1'b1; alu_ctl = C_R; func3 = 3'd0; func7 = 7'h01; op_a = 32'h1234; op_b = 32'h5678;
    repeat (6) @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rstmid_stall got %b want 0", stall); end
    checks++; if (md_valid !== 1'b0) begin errors++; $display("FAIL rstmid_md_valid got %b want 0", md_valid); end
    checks++; if (md_result !== 32'd0) begin errors++; $display("FAIL rstmid_md_result got %h want 0", md_result); end
    @(negedge clk);
    idle_inputs();
    reset_n = 1'b1;
    run_m(3'd0, 32'd3, 32'd4, r, sc, vc, vcyc);
    checks++; if (r !== 32'd12) begin errors++; $display("FAIL rstmid_mul got %h want 0000000c", r); end
    checks++; if (vc != 1) begin errors++; $display("FAIL rstmid_mul_valid got %0d want 1", vc); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a1, b1, a2, b2, r1, r2;
    bit g1, g2;
    int sc;
    a1 = $urandom; b1 = $urandom; a2 = $urandom; b2 = $urandom_range(1, 1000);
    @(negedge clk);
    in_valid = 1'b1; alu_ctl = C_R; func3 = 3'd1; func7 = 7'h01; op_a = a1; op_b = b1;
    g1 = 0; r1 = '0;
    for (int c = 0; c < 100 && !g1; c++) begin
      #1;
      if (md_valid) begin g1 = 1; r1 = md_result; end
      else @(negedge clk);
    end
    @(negedge clk);
    func3 = 3'd5; op_a = a2; op_b = b2;
    g2 = 0; r2 = '0; sc = 0;
    for (int c = 0; c < 100 && !g2; c++) begin
      #1;
      if (stall) sc++;
      if (md_valid) begin g2 = 1; r2 = md_result; end
      else @(negedge clk);
    end
    @(negedge clk);
    idle_inputs();
    checks++; if (!g1 || r1 !== ref_md(3'd1, a1, b1))
      begin errors++; $display("FAIL b2b_first got %h want %h", r1, ref_md(3'd1, a1, b1)); end
    checks++; if (!g2 || r2 !== ref_md(3'd5, a2, b2))
      begin errors++; $display("FAIL b2b_second got %h want %h", r2, ref_md(3'd5, a2, b2)); end
    checks++; if (sc != 33) begin errors++; $display("FAIL b2b_second_stall got %0d want 33", sc); end
  endtask

  task automatic test_random();
    logic [31:0] a, b, r, e;
    logic [2:0] f3;
    int sc, vc, vcyc, kind, esc;
    for (int i = 0; i < 40; i++) begin
      f3 = 3'($urandom_range(0, 7));
      kind = $urandom_range(0, 7);
      a = $urandom; b = $urandom;
      if (kind == 0) b = 32'd0;
      if (kind == 1) begin a = MIN32; b = 32'hFFFF_FFFF; end
      if (kind == 2) begin a = $urandom_range(0, 300) - 150; b = $urandom_range(1, 20); end
      if (kind == 3) b = 32'hFFFF_FFFF;
      e = ref_md(f3, a, b);
      esc = ref_special(f3, a, b) ? 1 : 33;
      run_m(f3, a, b, r, sc, vc, vcyc);
      checks++; if (r !== e)
        begin errors++; $display("FAIL rand_result f3=%0d a=%h b=%h got %h want %h", f3, a, b, r, e); end
      checks++; if (sc != esc || vcyc != esc || vc != 1)
        begin errors++; $display("FAIL rand_timing f3=%0d a=%h b=%h got stall %0d cyc %0d cnt %0d want %0d %0d 1", f3, a, b, sc, vcyc, vc, esc, esc); end
    end
  endtask

  initial begin
    test_reset();
    test_decode();
    test_mul();
    test_high_mul();
    test_div_special();
    test_div();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
